// File: rtl/wb_stage.sv
// wb_stage - write-back stage of the RV32I pipeline.
//
// Aligns and sign/zero-extends load data, selects between load data and the
// ALU result, writes the integer register file, serves the ID-stage read
// ports with same-cycle write-through, and counts retired register writes.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   cmd_ld_wb          instruction in WB is a load
//   ld_code_wb[2:0]    load funct3 (LB/LH/LW/LBU/LHU)
//   rd_adr_wb[4:0]     destination register
//   rd_data_wb[31:0]   ALU result / load effective address
//   wbk_rd_reg_wb      write-back request
//   ld_data_wb[31:0]   raw word returned by RAM or IO
//   stall, stall_1shot, stall_dly   stall level, first stall cycle, delayed stall
//   rst_pipe           synchronous pipeline flush
//   rs1/rs2_adr_id     ID read addresses; rs1/rs2_data_id combinational data
//   wbk_en/adr/data_fw forwarding of the write made this cycle
//   wbk_en/adr/data_dly  the same, one cycle older
//   retire_cnt         count of committed register writes
module wb_stage #(
  parameter int CNT_WIDTH     = 64,
  parameter bit RF_CLR_ON_RST = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_ld_wb,
  input  logic [2:0]           ld_code_wb,
  input  logic [4:0]           rd_adr_wb,
  input  logic [31:0]          rd_data_wb,
  input  logic                 wbk_rd_reg_wb,
  input  logic [31:0]          ld_data_wb,
  input  logic                 stall,
  input  logic                 stall_1shot,
  input  logic                 stall_dly,
  input  logic                 rst_pipe,
  input  logic [4:0]           rs1_adr_id,
  input  logic [4:0]           rs2_adr_id,
  output logic [31:0]          rs1_data_id,
  output logic [31:0]          rs2_data_id,
  output logic                 wbk_en_fw,
  output logic [4:0]           wbk_adr_fw,
  output logic [31:0]          wbk_data_fw,
  output logic                 wbk_en_dly,
  output logic [4:0]           wbk_adr_dly,
  output logic [31:0]          wbk_data_dly,
  output logic [CNT_WIDTH-1:0] retire_cnt
);

  // The stall level itself is not needed: the 1-shot/delayed pair fully
  // describes when the hold register is captured and consumed.
  logic unused_stall;
  assign unused_stall = stall;

  // Load data arrives only in the first stall cycle; hold it so the aligner
  // still sees it when the stall releases.
  logic [31:0] ld_hold_reg;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           ld_hold_reg <= '0;
    else if (rst_pipe)    ld_hold_reg <= '0;
    else if (stall_1shot) ld_hold_reg <= ld_data_wb;
  end

  logic [31:0] ld_raw;
  assign ld_raw = stall_dly ? ld_hold_reg : ld_data_wb;

  // Aligner
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_aligned;

  always_comb begin
    ld_byte = ld_raw[7:0];
    case (rd_data_wb[1:0])
      2'd0: ld_byte = ld_raw[7:0];
      2'd1: ld_byte = ld_raw[15:8];
      2'd2: ld_byte = ld_raw[23:16];
      2'd3: ld_byte = ld_raw[31:24];
      default: ld_byte = ld_raw[7:0];
    endcase
  end

  // Misaligned halfword offsets fall back to the enclosing half.
  assign ld_half = rd_data_wb[1] ? ld_raw[31:16] : ld_raw[15:0];

  always_comb begin
    ld_aligned = 32'd0;
    case (ld_code_wb)
      3'b000: ld_aligned = {{24{ld_byte[7]}}, ld_byte};
      3'b001: ld_aligned = {{16{ld_half[15]}}, ld_half};
      3'b010: ld_aligned = ld_raw;
      3'b100: ld_aligned = {24'd0, ld_byte};
      3'b101: ld_aligned = {16'd0, ld_half};
      default: ld_aligned = 32'd0;
    endcase
  end

  // Forwarding; a flush suppresses both the write and its count.
  assign wbk_data_fw = cmd_ld_wb ? ld_aligned : rd_data_wb;
  assign wbk_en_fw   = wbk_rd_reg_wb & (rd_adr_wb != 5'd0) & ~rst_pipe;
  assign wbk_adr_fw  = rd_adr_wb;

  // Register file x1..x31; x0 has no storage.
  logic [31:0] rf_reg [1:31];

  generate
    if (RF_CLR_ON_RST) begin : g_rf_clr
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 1; i < 32; i++) rf_reg[i] <= '0;
        end else if (wbk_en_fw) begin
          rf_reg[rd_adr_wb] <= wbk_data_fw;
        end
      end
    end else begin : g_rf_noclr
      always_ff @(posedge clk) begin
        if (wbk_en_fw) rf_reg[rd_adr_wb] <= wbk_data_fw;
      end
    end
  endgenerate

  // Read ports with write-through so ID sees the WB result before it lands.
  logic [4:0]  rd_port_adr  [2];
  logic [31:0] rd_port_data [2];
  assign rd_port_adr[0] = rs1_adr_id;
  assign rd_port_adr[1] = rs2_adr_id;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd_port
      always_comb begin
        if (rd_port_adr[gi] == 5'd0)
          rd_port_data[gi] = 32'd0;
        else if (wbk_en_fw && (rd_port_adr[gi] == rd_adr_wb))
          rd_port_data[gi] = wbk_data_fw;
        else
          rd_port_data[gi] = rf_reg[rd_port_adr[gi]];
      end
    end
  endgenerate

  assign rs1_data_id = rd_port_data[0];
  assign rs2_data_id = rd_port_data[1];

  // Delayed forwarding copy, never stall-gated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbk_en_dly   <= 1'b0;
      wbk_adr_dly  <= '0;
      wbk_data_dly <= '0;
    end else begin
      wbk_en_dly   <= rst_pipe ? 1'b0 : wbk_en_fw;
      wbk_adr_dly  <= wbk_adr_fw;
      wbk_data_dly <= wbk_data_fw;
    end
  end

  // Retired-write counter, wraps naturally; survives pipeline flushes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         retire_cnt <= '0;
    else if (wbk_en_fw) retire_cnt <= retire_cnt + 1'b1;
  end

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_ld_wb;
  logic [2:0]    ld_code_wb;
  logic [4:0]    rd_adr_wb;
  logic [31:0]   rd_data_wb;
  logic          wbk_rd_reg_wb;
  logic [31:0]   ld_data_wb;
  logic          stall, stall_1shot, stall_dly, rst_pipe;
  logic [4:0]    rs1_adr_id, rs2_adr_id;
  logic [31:0]   rs1_data_id, rs2_data_id;
  logic          wbk_en_fw;
  logic [4:0]    wbk_adr_fw;
  logic [31:0]   wbk_data_fw;
  logic          wbk_en_dly;
  logic [4:0]    wbk_adr_dly;
  logic [31:0]   wbk_data_dly;
  logic [CW-1:0] retire_cnt;

  always #5 clk = ~clk;

  wb_stage #(.CNT_WIDTH(CW), .RF_CLR_ON_RST(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_ld_wb(cmd_ld_wb), .ld_code_wb(ld_code_wb),
    .rd_adr_wb(rd_adr_wb), .rd_data_wb(rd_data_wb), .wbk_rd_reg_wb(wbk_rd_reg_wb),
    .ld_data_wb(ld_data_wb), .stall(stall), .stall_1shot(stall_1shot),
    .stall_dly(stall_dly), .rst_pipe(rst_pipe), .rs1_adr_id(rs1_adr_id),
    .rs2_adr_id(rs2_adr_id), .rs1_data_id(rs1_data_id), .rs2_data_id(rs2_data_id),
    .wbk_en_fw(wbk_en_fw), .wbk_adr_fw(wbk_adr_fw), .wbk_data_fw(wbk_data_fw),
    .wbk_en_dly(wbk_en_dly), .wbk_adr_dly(wbk_adr_dly), .wbk_data_dly(wbk_data_dly),
    .retire_cnt(retire_cnt)
  );

  typedef struct {
    logic        ld;
    logic [2:0]  code;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] raw;
    logic [31:0] exp_data;
    logic        exp_en;
  } vec_t;

  vec_t          vecs [12];
  int            errors = 0;
  int            checks = 0;
  logic [CW-1:0] exp_cnt = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic idle_inputs();
    cmd_ld_wb = 0; ld_code_wb = 3'b000; rd_adr_wb = 0; rd_data_wb = 0;
    wbk_rd_reg_wb = 0; ld_data_wb = 0; stall = 0; stall_1shot = 0;
    stall_dly = 0; rst_pipe = 0; rs1_adr_id = 0; rs2_adr_id = 0;
  endtask

  // Drive one write-back request at the current negedge.
  task automatic drive_wb(input logic ld, input logic [2:0] code, input logic [4:0] rd,
                          input logic [31:0] alu, input logic [31:0] raw);
    cmd_ld_wb = ld; ld_code_wb = code; rd_adr_wb = rd; rd_data_wb = alu;
    ld_data_wb = raw; wbk_rd_reg_wb = 1'b1;
  endtask

  initial begin
    //            ld   code    rd  alu/address   raw word      expected      en
    vecs[0]  = '{1'b1, 3'b000, 5,  32'h1000,     32'h808182F3, 32'hFFFFFFF3, 1'b1};
    vecs[1]  = '{1'b1, 3'b100, 6,  32'h1003,     32'h808182F3, 32'h00000080, 1'b1};
    vecs[2]  = '{1'b1, 3'b001, 8,  32'h2002,     32'h80017FFF, 32'hFFFF8001, 1'b1};
    vecs[3]  = '{1'b1, 3'b101, 9,  32'h2000,     32'h80017FFF, 32'h00007FFF, 1'b1};
    vecs[4]  = '{1'b1, 3'b010, 10, 32'h2000,     32'h80017FFF, 32'h80017FFF, 1'b1};
    vecs[5]  = '{1'b0, 3'b000, 7,  32'h1234,     32'hFFFFFFFF, 32'h00001234, 1'b1};
    vecs[6]  = '{1'b0, 3'b000, 0,  32'h5555,     32'h0,        32'h00005555, 1'b0};
    vecs[7]  = '{1'b1, 3'b000, 11, 32'h3001,     32'h808182F3, 32'hFFFFFF82, 1'b1};
    vecs[8]  = '{1'b1, 3'b100, 12, 32'h3002,     32'h808182F3, 32'h00000081, 1'b1};
    vecs[9]  = '{1'b1, 3'b101, 13, 32'h3003,     32'h808182F3, 32'h00008081, 1'b1};
    vecs[10] = '{1'b1, 3'b011, 14, 32'h3000,     32'h808182F3, 32'h00000000, 1'b1};
    vecs[11] = '{1'b0, 3'b000, 31, 32'hCAFEF00D, 32'h0,        32'hCAFEF00D, 1'b1};

    idle_inputs();
    rst_n = 1'b0;
    rs1_adr_id = 5;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rs1", rs1_data_id, 32'd0);
    chk("rst_en_fw", {31'd0, wbk_en_fw}, 32'd0);
    chk("rst_en_dly", {31'd0, wbk_en_dly}, 32'd0);
    chk("rst_data_dly", wbk_data_dly, 32'd0);
    chk("rst_cnt", {28'd0, retire_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven single-cycle write-backs.
    for (int v = 0; v < 12; v++) begin
      @(negedge clk);
      drive_wb(vecs[v].ld, vecs[v].code, vecs[v].rd, vecs[v].alu, vecs[v].raw);
      rs1_adr_id = vecs[v].rd;
      rs2_adr_id = 0;
      #1;
      $display("vec %0d rd=%0d ld=%0b code=%b data_fw=%h en_fw=%0b",
               v, vecs[v].rd, vecs[v].ld, vecs[v].code, wbk_data_fw, wbk_en_fw);
      chk($sformatf("v%0d_data_fw", v), wbk_data_fw, vecs[v].exp_data);
      chk($sformatf("v%0d_en_fw", v), {31'd0, wbk_en_fw}, {31'd0, vecs[v].exp_en});
      chk($sformatf("v%0d_adr_fw", v), {27'd0, wbk_adr_fw}, {27'd0, vecs[v].rd});
      chk($sformatf("v%0d_bypass", v), rs1_data_id, vecs[v].rd == 0 ? 32'd0 : vecs[v].exp_data);
      @(posedge clk);
      if (vecs[v].exp_en) exp_cnt++;
      #1;
      wbk_rd_reg_wb = 1'b0;
      rs2_adr_id = vecs[v].rd;
      #1;
      chk($sformatf("v%0d_stored", v), rs2_data_id, vecs[v].exp_en ? vecs[v].exp_data : 32'd0);
      chk($sformatf("v%0d_data_dly", v), wbk_data_dly, vecs[v].exp_data);
      chk($sformatf("v%0d_en_dly", v), {31'd0, wbk_en_dly}, {31'd0, vecs[v].exp_en});
      chk($sformatf("v%0d_cnt", v), {28'd0, retire_cnt}, {28'd0, exp_cnt});
    end

    // Stalled load: data captured on stall_1shot, consumed under stall_dly.
    @(negedge clk);
    idle_inputs();
    stall = 1; stall_1shot = 1; ld_data_wb = 32'hDEADBEEF;
    @(negedge clk);
    stall_1shot = 0; stall_dly = 1;
    drive_wb(1'b1, 3'b010, 15, 32'h4000, 32'h0);
    rs1_adr_id = 15;
    #1;
    $display("stall load rd=15 data_fw=%h", wbk_data_fw);
    chk("stall_data_fw", wbk_data_fw, 32'hDEADBEEF);
    chk("stall_bypass", rs1_data_id, 32'hDEADBEEF);
    @(posedge clk);
    exp_cnt++;
    @(negedge clk);
    idle_inputs();

    // Flush wins over a pending write.
    drive_wb(1'b0, 3'b000, 16, 32'h77, 32'h0);
    rst_pipe = 1; rs1_adr_id = 16;
    #1;
    $display("flush rd=16 en_fw=%0b", wbk_en_fw);
    chk("flush_en_fw", {31'd0, wbk_en_fw}, 32'd0);
    chk("flush_bypass", rs1_data_id, 32'd0);
    @(posedge clk);
    #1;
    idle_inputs();
    rs1_adr_id = 16;
    #1;
    chk("flush_no_write", rs1_data_id, 32'd0);
    chk("flush_en_dly", {31'd0, wbk_en_dly}, 32'd0);
    chk("flush_cnt", {28'd0, retire_cnt}, {28'd0, exp_cnt});

    // Drive the counter to all-ones, then one more write wraps it.
    for (int i = 0; i < 20 && exp_cnt != 4'hF; i++) begin
      @(negedge clk);
      drive_wb(1'b0, 3'b000, 20, i, 32'h0);
      @(posedge clk);
      exp_cnt++;
    end
    @(negedge clk);
    idle_inputs();
    #1;
    $display("counter at %0d", retire_cnt);
    chk("cnt_full", {28'd0, retire_cnt}, 32'd15);
    drive_wb(1'b0, 3'b000, 20, 32'h99, 32'h0);
    @(posedge clk);
    #1;
    $display("counter after wrap %0d", retire_cnt);
    chk("cnt_wrap", {28'd0, retire_cnt}, 32'd0);

    // Asynchronous reset in the middle of a stall clears the hold register.
    @(negedge clk);
    idle_inputs();
    stall = 1; stall_1shot = 1; ld_data_wb = 32'hA5A5A5A5;
    @(negedge clk);
    stall_1shot = 0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    rs1_adr_id = 7;
    stall_dly = 1;
    drive_wb(1'b1, 3'b010, 21, 32'h0, 32'h11111111);
    #1;
    $display("post-reset stalled load data_fw=%h", wbk_data_fw);
    chk("rst_hold_clear", wbk_data_fw, 32'd0);
    chk("rst_rf_clear", rs1_data_id, 32'd0);
    chk("rst_cnt_again", {28'd0, retire_cnt}, 32'd0);
    @(negedge clk);
    idle_inputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
